// File: rtl/hangman_pkg.sv
// hangman_pkg: shared game-state codes, load codes and guess_sequencer state encoding
package hangman_pkg;
  localparam int NUM_LETTERS = 26;
  localparam logic [4:0] START_CODE = 5'd26;
  typedef enum logic [1:0] {GS_START, GS_INGAME, GS_WINGAME, GS_LOSTGAME} game_state_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_ISSUE, S_SETTLE, S_PLAY, S_OVER} seq_state_e;
endpackage

// File: rtl/guess_sequencer_word_counter.sv
// word_counter: free-running modulo-WORD_COUNT counter used to pick the next word
module word_counter #(
  parameter int WORD_COUNT = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] count
);
  logic [ADDR_W-1:0] count_q, count_d;
  always_comb count_d = (count_q == ADDR_W'(WORD_COUNT - 1)) ? '0 : count_q + 1'b1;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/guess_sequencer.sv
// guess_sequencer: sequences word fetch, start load and filtered guess loads into game_handler
module guess_sequencer
  import hangman_pkg::*;
#(
  parameter int WORD_COUNT = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   key_valid,
  input  logic [4:0]             key_code,
  output logic                   key_ready,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [NUM_LETTERS-1:0] rom_mask,
  output logic [NUM_LETTERS-1:0] mask,
  output logic                   load,
  output logic [4:0]             load_x,
  input  logic [1:0]             game_state,
  output logic [NUM_LETTERS-1:0] tried,
  output logic                   repeat_pulse,
  output logic                   busy
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, word_ctr;
  logic [NUM_LETTERS-1:0] mask_q, mask_d, tried_q, tried_d, key_bit;
  logic [4:0] load_x_q, load_x_d;
  logic repeat_q, repeat_d;
  logic key_ok, key_rep, fetch_last, accept_ng, guess;

  word_counter #(.WORD_COUNT(WORD_COUNT), .ADDR_W(ADDR_W)) u_word_counter (
    .clk(clk), .reset(reset), .count(word_ctr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      mask_q     <= '0;
      load_x_q   <= '0;
      tried_q    <= '0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      mask_q     <= mask_d;
      load_x_q   <= load_x_d;
      tried_q    <= tried_d;
      repeat_q   <= repeat_d;
    end
  end

  always_comb begin
    key_bit    = NUM_LETTERS'(1) << key_code;
    key_ok     = key_valid && (key_code < START_CODE);
    key_rep    = |(tried_q & key_bit);
    fetch_last = (state_q == S_FETCH) && (cnt_q == CW'(1));
    accept_ng  = new_game && (state_q inside {S_IDLE, S_OVER, S_PLAY});
    guess      = (state_q == S_PLAY) && !new_game && key_ok && !key_rep;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: state_d = new_game ? S_FETCH : state_q;
      S_FETCH:        state_d = fetch_last ? S_START : S_FETCH;
      S_START,
      S_ISSUE:        state_d = S_SETTLE;
      S_SETTLE:       state_d = (cnt_q != LAST) ? S_SETTLE :
                                (game_state == GS_INGAME) ? S_PLAY : S_OVER;
      S_PLAY:         state_d = new_game ? S_FETCH : guess ? S_ISSUE : S_PLAY;
      default:        state_d = S_IDLE;
    endcase
  end

  // cnt times both the FETCH and SETTLE phases and restarts on every state change
  always_comb begin
    cnt_d      = ((state_q inside {S_FETCH, S_SETTLE}) && state_d == state_q) ? cnt_q + 1'b1 : '0;
    rom_addr_d = accept_ng ? word_ctr : rom_addr_q;
    mask_d     = fetch_last ? rom_mask : mask_q;
    load_x_d   = fetch_last ? START_CODE : guess ? key_code : load_x_q;
    tried_d    = (state_q == S_START) ? '0 : guess ? (tried_q | key_bit) : tried_q;
    repeat_d   = (state_q == S_PLAY) && !new_game && key_ok && key_rep;
  end

  always_comb begin
    load      = state_q inside {S_START, S_ISSUE};
    busy      = state_q inside {S_FETCH, S_START, S_ISSUE, S_SETTLE};
    key_ready = state_q == S_PLAY;
  end

  assign rom_addr     = rom_addr_q;
  assign mask         = mask_q;
  assign load_x       = load_x_q;
  assign tried        = tried_q;
  assign repeat_pulse = repeat_q;
endmodule
